// File: rtl/gated_count_ctrl.sv
// gated_count_ctrl: windowed event counter with synchronized edge detect and valid/ack result hold.
// Build option: define COUNT_SAT_EN to saturate the event count instead of wrapping.
module gated_count_ctrl #(
   parameter int CNT_W       = 10,
   parameter int GATE_W      = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              ev_in,
   output logic              busy,
   output logic [CNT_W-1:0]  count,
   output logic              ovf,
   output logic              res_valid,
   input  logic              res_ack
);
   typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic prev, ev_p, at_max, done;
   logic [GATE_W-1:0] timer;
   logic [CNT_W-1:0] cnt_int, cnt_nx;
   logic ovf_int, ovf_nx;
   assign ev_p   = sync[SYNC_STAGES-1] & ~prev;
   assign at_max = &cnt_int;
   assign ovf_nx = ovf_int | (ev_p & at_max);
   assign done   = (state == COUNT) && !abort && (timer == GATE_W'(1));
`ifdef COUNT_SAT_EN
   assign cnt_nx = (ev_p && !at_max) ? cnt_int + CNT_W'(1) : cnt_int;
`else
   assign cnt_nx = cnt_int + CNT_W'(ev_p);
`endif
   // synchronize the raw event line and keep one cycle of history for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], ev_in};
         prev <= sync[SYNC_STAGES-1];
      end
   end
   // next-state selection; abort wins over everything outside IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (start && !abort) ? COUNT : IDLE;
         COUNT:   state_nx = abort ? IDLE : (timer == GATE_W'(1)) ? HOLD : COUNT;
         HOLD:    state_nx = (res_ack || abort) ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   // state register with busy registered alongside it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
      end
   end
   // window timer and running count; a zero gate length still opens one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer   <= '0;
         cnt_int <= '0;
         ovf_int <= 1'b0;
      end else if (state == IDLE && start && !abort) begin
         timer   <= (gate_len == '0) ? GATE_W'(1) : gate_len;
         cnt_int <= '0;
         ovf_int <= 1'b0;
      end else if (state == COUNT) begin
         timer   <= timer - GATE_W'(1);
         cnt_int <= cnt_nx;
         ovf_int <= ovf_nx;
      end
   end
   // latch the result at window close, including the last open cycle's edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         ovf       <= 1'b0;
         res_valid <= 1'b0;
      end else if (done) begin
         count     <= cnt_nx;
         ovf       <= ovf_nx;
         res_valid <= 1'b1;
      end else if (state == HOLD && (res_ack || abort)) begin
         res_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_gated_count_ctrl.sv
// tb_gated_count_ctrl: directed and randomized checks of gated_count_ctrl against an edge-counting reference.
module tb_gated_count_ctrl;
   localparam int CNT_W  = 10;
   localparam int GATE_W = 24;
   localparam int S      = 2;
   localparam int MAX    = (1 << CNT_W) - 1;
`ifdef COUNT_SAT_EN
   localparam int OVF_CNT = MAX;
`else
   localparam int OVF_CNT = 1030 % (MAX + 1);
`endif
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ev_in = 1'b0, res_ack = 1'b0;
   logic [GATE_W-1:0] gate_len = '0;
   logic busy, ovf, res_valid;
   logic [CNT_W-1:0] count;
   int errors = 0, checks = 0;

   gated_count_ctrl #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
      .ev_in(ev_in), .busy(busy), .count(count), .ovf(ovf), .res_valid(res_valid), .res_ack(res_ack)
   );

   always #5 clk = ~clk;

   // reference: a rising edge of the sampled pin is seen S edges later; count edges as a plain integer
   int m_state, m_left, m_edges;
   logic m_last, m_pulse;
   bit m_rq[$];
   logic [CNT_W-1:0] m_count;
   logic m_ovf, m_valid, m_busy;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_left = 0; m_edges = 0; m_last = 1'b0; m_rq.delete();
         m_count = '0; m_ovf = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
      end else begin
         m_pulse = 1'b0;
         m_rq.push_back(ev_in & ~m_last);
         m_last = ev_in;
         if (m_rq.size() > S) m_pulse = m_rq.pop_front();
         if (m_state == 0) begin
            if (start && !abort) begin
               m_left = (gate_len == 0) ? 1 : int'(gate_len);
               m_edges = 0;
               m_state = 1;
            end
         end else if (m_state == 1) begin
            if (abort) m_state = 0;
            else begin
               m_edges += int'(m_pulse);
               m_left--;
               if (m_left == 0) begin
`ifdef COUNT_SAT_EN
                  m_count = CNT_W'((m_edges > MAX) ? MAX : m_edges);
`else
                  m_count = CNT_W'(m_edges % (MAX + 1));
`endif
                  m_ovf = (m_edges > MAX);
                  m_valid = 1'b1;
                  m_state = 2;
               end
            end
         end else if (res_ack || abort) begin
            m_valid = 1'b0;
            m_state = 0;
         end
         m_busy = (m_state != 0);
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      chk("count", 32'(count), 32'(m_count));
      chk("ovf", 32'(ovf), 32'(m_ovf));
   endtask

   task automatic go(int g);
      gate_len = GATE_W'(g);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic ack();
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
   endtask

   task automatic pulses(int n, int lo, int hi);
      for (int i = 0; i < n; i++) begin
         ev_in = 1'b1;
         repeat ($urandom_range(lo, hi)) step();
         ev_in = 1'b0;
         repeat ($urandom_range(lo, hi)) step();
      end
   endtask

   task automatic wait_valid(int budget);
      int i = 0;
      while (!res_valid && i < budget) begin
         step();
         i++;
      end
      chk("wait_valid", 32'(res_valid), 32'd1);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
   endtask

   initial begin
      #1;
      chk_zero("reset");
      repeat (3) step();
      rst_n = 1'b1;
      repeat (3) step();
      chk_zero("idle");
      // window of 100 with no events
      go(100);
      repeat (99) step();
      chk("g100_early", 32'(res_valid), 32'd0);
      step();
      chk("g100_valid", 32'(res_valid), 32'd1);
      chk("g100_count", 32'(count), 32'd0);
      chk("g100_ovf", 32'(ovf), 32'd0);
      ack();
      // 37 slow pulses inside a 1000 window, ack after 5 cycles
      go(1000);
      pulses(37, 4, 7);
      wait_valid(1000);
      chk("c37_count", 32'(count), 32'd37);
      chk("c37_ovf", 32'(ovf), 32'd0);
      repeat (5) step();
      ack();
      chk("c37_ack_valid", 32'(res_valid), 32'd0);
      chk("c37_ack_busy", 32'(busy), 32'd0);
      // abort after 20 edges keeps the previous result
      go(1000);
      pulses(20, 2, 4);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_count", 32'(count), 32'd37);
      chk("abort_valid", 32'(res_valid), 32'd0);
      // start masked by abort in IDLE
      gate_len = GATE_W'(50);
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("startabort_busy", 32'(busy), 32'd0);
      step();
      chk("startabort_busy2", 32'(busy), 32'd0);
      // gate 10: edge seen in start cycle dropped, edge in last open cycle kept, later one dropped
      gate_len = GATE_W'(10);
      for (int i = 0; i < 17; i++) begin
         ev_in = (i == 1 || i == 11 || i == 13);
         start = (i == 3);
         step();
      end
      start = 1'b0;
      ev_in = 1'b0;
      chk("g10_valid", 32'(res_valid), 32'd1);
      chk("g10_count", 32'(count), 32'd1);
      chk("g10_ovf", 32'(ovf), 32'd0);
      ack();
      // gate 0 acts as a one-cycle window
      gate_len = '0;
      for (int i = 0; i < 4; i++) begin
         ev_in = (i == 1);
         start = (i == 2);
         step();
      end
      start = 1'b0;
      ev_in = 1'b0;
      chk("g0_valid", 32'(res_valid), 32'd1);
      chk("g0_count", 32'(count), 32'd1);
      ack();
      // 1030 edges overflow the counter
      go(5000);
      pulses(1030, 1, 2);
      wait_valid(5000);
      chk("ovf_count", 32'(count), 32'(OVF_CNT));
      chk("ovf_flag", 32'(ovf), 32'd1);
      ack();
      // start in HOLD ignored, start right after ack accepted
      go(20);
      wait_valid(40);
      start = 1'b1;
      repeat (3) step();
      chk("hold_start_busy", 32'(busy), 32'd1);
      chk("hold_start_valid", 32'(res_valid), 32'd1);
      ack();
      chk("ack_busy", 32'(busy), 32'd0);
      step();
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'd1);
      // reset mid-window
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk_zero("rst_count");
      step();
      rst_n = 1'b1;
      step();
      // reset while holding a result
      go(5);
      wait_valid(10);
      rst_n = 1'b0;
      #1;
      chk_zero("rst_hold");
      step();
      rst_n = 1'b1;
      step();
      // random windows with random events, aborts, acks and stray starts
      for (int w = 0; w < 8; w++) begin
         int g;
         g = int'($urandom_range(0, 200));
         go(g);
         repeat (g + 20) begin
            ev_in = 1'($urandom_range(0, 1));
            abort = ($urandom_range(0, 299) == 0);
            res_ack = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 15) == 0);
            gate_len = GATE_W'($urandom_range(0, 60));
            step();
         end
         ev_in = 1'b0;
         abort = 1'b0;
         start = 1'b0;
         res_ack = 1'b1;
         repeat (70) step();
         res_ack = 1'b0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule

// File: doc/gated_count_ctrl.md
Name: gated_count_ctrl

Overview:
- Controller that sequences a 10-bit event counter over a programmable gate window: synchronizes a raw event line, edge-detects it, counts rising edges only while the window is open, then latches the result.
- Result is held with a valid/ack handshake.
- Sits between board-level event inputs (buttons, external pulses) and display/readout logic, replacing free-running ripple counting with a single-clock, windowed measurement.

Parameters:
CNT_W, 10, width of event count and result
GATE_W, 24, width of gate-length input and internal gate timer
SYNC_STAGES, 2, flops in ev_in synchronizer (min 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  begin a measurement; sampled only in IDLE
abort  input  1  cancel active window or drop held result
gate_len  input  GATE_W  window length in clk cycles; sampled when start is accepted
ev_in  input  1  raw asynchronous event line
busy  output  1  high in COUNT and HOLD
count  output  CNT_W  latched result of last completed window
ovf  output  1  counter wrapped (or saturated) during last completed window
res_valid  output  1  result available; held until res_ack or abort
res_ack  input  1  consumer accepted result

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; count=0, ovf=0, res_valid=0, busy=0; synchronizer and edge-history flops=0; gate timer and internal counter=0.
- Event path: ev_in -> SYNC_STAGES flops -> rising-edge detector (synced & ~prev). Produces a 1-cycle pulse ev_p. Pin-to-pulse latency is SYNC_STAGES+1 clk. Detector runs in all states; pulses outside COUNT are discarded.
- FSM states: IDLE, COUNT, HOLD.
- IDLE:
  - start=1 and abort=0 at edge T: load timer=gate_len (gate_len=0 treated as 1), clear internal count and ovf_int, go to COUNT.
  - abort=1 masks start.
- COUNT:
  - Open cycles are T+1 .. T+N, where N = effective gate_len.
  - Each open cycle with ev_p=1: cnt_int += 1.
  - Increment from 2^CNT_W-1 wraps to 0 and sets ovf_int (sticky for the window).
  - The timer decrements each cycle.
  - In cycle T+N (timer==1), the ev_p of that cycle is included. At edge T+N: count <= final cnt_int, ovf <= ovf_int, res_valid <= 1, go to HOLD.
  - Outputs are therefore visible from cycle T+N+1.
  - ev_p in cycle T (start cycle) is not counted.
  - start in COUNT is ignored.
- HOLD:
  - count/ovf are stable; res_valid=1.
  - res_ack=1 -> res_valid <= 0, go to IDLE.
  - abort=1 (with or without ack) -> same as ack.
  - start is ignored; new measurement requires a return to IDLE first (earliest accepted start is the cycle after ack).
- Abort in COUNT: go to IDLE next edge; count, ovf, res_valid keep previous values (res_valid already 0); partial count is discarded.
- busy = (state != IDLE), registered with the state.
- Reset mid-window: immediate return to reset values; no partial result is latched.

Optional Feature:
- COUNT_SAT_EN defined: cnt_int saturates at 2^CNT_W-1 instead of wrapping. ovf_int is set on the first suppressed increment. count reports 1023 (CNT_W=10) for any window with >1023 edges.
- Not defined: modulo 2^CNT_W wrap as described in Behaviour; ovf still flags the wrap.

Test Plan:
- Reset release, no activity -> count=0, ovf=0, res_valid=0, busy=0. start with gate_len=100 and no edges -> res_valid rises at T+101, count=0, ovf=0.
- gate_len=1000; drive 37 ev_in pulses (each high ≥4 clk), all inside the window after sync latency -> count=37, ovf=0. res_ack at +5 cycles -> res_valid=0 and busy=0 next cycle.
- Boundary: gate_len=10; ev_p timed to land exactly in cycle T+10, then another in T+11 -> count=1 (only the T+10 edge counts). gate_len=0 behaves as 1.
- Overflow: gate_len=5000; 1030 edges -> count=6, ovf=1 without COUNT_SAT_EN; count=1023, ovf=1 with COUNT_SAT_EN.
- Abort mid-COUNT after 20 edges with prior held count=37 -> IDLE, count stays 37, res_valid stays 0. start+abort same cycle in IDLE -> no transition.
- rst_n asserted in COUNT and in HOLD -> all outputs 0 asynchronously. start in HOLD ignored; start in the cycle after ack is accepted.
